// File: rtl/ccb_tx_pkg.sv
// Shared types and constants for the CCB transmit driver.
package ccb_tx_pkg;

    localparam int unsigned BX_PERIOD_DEF   = 3564;
    localparam int unsigned STB_WIDTH_DEF   = 1;
    localparam int unsigned L1A_MIN_GAP_DEF = 4;

    localparam int unsigned CCB_BYTE_W = 8;
    localparam int unsigned BXN_W      = 12;
    localparam int unsigned GAP_W      = 4;
    localparam int unsigned STB_CNT_W  = 3;

    localparam logic [CCB_BYTE_W-1:0] CCB_IDLE_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } strobe_state_e;

    // Next bunch-crossing number with wrap at the end of the orbit.
    function automatic logic [BXN_W-1:0] bx_next(input logic [BXN_W-1:0] bx,
                                                 input int unsigned      period);
        return (bx == BXN_W'(period - 1)) ? '0 : bx + BXN_W'(1);
    endfunction

endpackage

// File: rtl/ccb_tx_driver_if.sv
// Request/acknowledge and CCB backplane signals of the transmit driver.
interface ccb_tx_driver_if;
    import ccb_tx_pkg::*;

    logic                  cmd_req;
    logic [CCB_BYTE_W-1:0] cmd_code;
    logic                  cmd_ack;
    logic                  data_req;
    logic [CCB_BYTE_W-1:0] data_byte;
    logic                  data_ack;
    logic                  l1a_req;
    logic                  l1a_drop;
    logic                  bx0_en;
    logic [BXN_W-1:0]      bxn;
    logic [CCB_BYTE_W-1:0] _ccb_cmd;
    logic                  _ccb_cmd_strobe;
    logic [CCB_BYTE_W-1:0] _ccb_data;
    logic                  _ccb_data_strobe;
    logic                  _ccb_l1accept;
    logic                  _ccb_bx0;

    // Host side: issues requests, observes acks and the backplane.
    modport master (
        output cmd_req, cmd_code, data_req, data_byte, l1a_req, bx0_en,
        input  cmd_ack, data_ack, l1a_drop, bxn,
               _ccb_cmd, _ccb_cmd_strobe, _ccb_data, _ccb_data_strobe,
               _ccb_l1accept, _ccb_bx0
    );

    // Driver side.
    modport slave (
        input  cmd_req, cmd_code, data_req, data_byte, l1a_req, bx0_en,
        output cmd_ack, data_ack, l1a_drop, bxn,
               _ccb_cmd, _ccb_cmd_strobe, _ccb_data, _ccb_data_strobe,
               _ccb_l1accept, _ccb_bx0
    );

endinterface

// File: rtl/ccb_strobe_tx.sv
// One strobed CCB byte channel: setup, STB_WIDTH-cycle low strobe, hold.
module ccb_strobe_tx
    import ccb_tx_pkg::*;
#(
    parameter int unsigned STB_WIDTH = STB_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [CCB_BYTE_W-1:0] byte_in,
    output logic                  ack,
    output logic [CCB_BYTE_W-1:0] ccb_bus,
    output logic                  ccb_strobe
);

    strobe_state_e         state_q, state_d;
    logic [STB_CNT_W-1:0]  cnt_q, cnt_d;
    logic [CCB_BYTE_W-1:0] byte_q, byte_d;
    logic                  ack_d;
    logic [CCB_BYTE_W-1:0] bus_d;
    logic                  strobe_d;

    // Next state, captured byte and the output values for the coming cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        ack_d    = 1'b0;
        bus_d    = CCB_IDLE_BYTE;
        strobe_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                    byte_d  = byte_in;
                    ack_d   = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
            end
            ST_STROBE: begin
                if (cnt_q == STB_CNT_W'(STB_WIDTH - 1)) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + STB_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        if (state_d != ST_IDLE) begin
            bus_d = ~byte_d;
        end
        strobe_d = (state_d != ST_STROBE);
    end

    // State and registered bus outputs; reset aborts any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            ack        <= 1'b0;
            ccb_bus    <= CCB_IDLE_BYTE;
            ccb_strobe <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            ack        <= ack_d;
            ccb_bus    <= bus_d;
            ccb_strobe <= strobe_d;
        end
    end

endmodule

// File: rtl/ccb_tx_driver.sv
// CCB transmit driver: command/data strobe channels, BX counter, L1A gap filter.
module ccb_tx_driver
    import ccb_tx_pkg::*;
#(
    parameter int unsigned BX_PERIOD   = BX_PERIOD_DEF,
    parameter int unsigned STB_WIDTH   = STB_WIDTH_DEF,
    parameter int unsigned L1A_MIN_GAP = L1A_MIN_GAP_DEF
) (
    input  logic            clk40,
    input  logic            _reset,
    ccb_tx_driver_if.slave  bus
);

    logic [BXN_W-1:0] bxn_q, bxn_d;
    logic             bx0_q, bx0_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             l1a_ok;
    logic             l1a_q, l1a_d;
    logic             drop_q, drop_d;

    ccb_strobe_tx #(
        .STB_WIDTH (STB_WIDTH)
    ) u_cmd_tx (
        .clk        (clk40),
        .rst_n      (_reset),
        .req        (bus.cmd_req),
        .byte_in    (bus.cmd_code),
        .ack        (bus.cmd_ack),
        .ccb_bus    (bus._ccb_cmd),
        .ccb_strobe (bus._ccb_cmd_strobe)
    );

    ccb_strobe_tx #(
        .STB_WIDTH (STB_WIDTH)
    ) u_data_tx (
        .clk        (clk40),
        .rst_n      (_reset),
        .req        (bus.data_req),
        .byte_in    (bus.data_byte),
        .ack        (bus.data_ack),
        .ccb_bus    (bus._ccb_data),
        .ccb_strobe (bus._ccb_data_strobe)
    );

    // Orbit counter and BX0 marker decoded from the upcoming count.
    always_comb begin
        bxn_d = bx_next(bxn_q, BX_PERIOD);
        bx0_d = !((bxn_d == '0) && bus.bx0_en);
    end

    // L1A acceptance against cycles elapsed since the last accepted L1A.
    always_comb begin
        l1a_ok = bus.l1a_req && (gap_q >= GAP_W'(L1A_MIN_GAP));
        gap_d  = gap_q;
        if (l1a_ok) begin
            gap_d = GAP_W'(1);
        end else if (gap_q < GAP_W'(L1A_MIN_GAP)) begin
            gap_d = gap_q + GAP_W'(1);
        end
        l1a_d  = !l1a_ok;
        drop_d = bus.l1a_req && !l1a_ok;
    end

    // Registered BX and L1A outputs; gap starts saturated so the first L1A passes.
    always_ff @(posedge clk40 or negedge _reset) begin
        if (!_reset) begin
            bxn_q  <= '0;
            bx0_q  <= 1'b1;
            gap_q  <= GAP_W'(L1A_MIN_GAP);
            l1a_q  <= 1'b1;
            drop_q <= 1'b0;
        end else begin
            bxn_q  <= bxn_d;
            bx0_q  <= bx0_d;
            gap_q  <= gap_d;
            l1a_q  <= l1a_d;
            drop_q <= drop_d;
        end
    end

    assign bus.bxn           = bxn_q;
    assign bus._ccb_bx0      = bx0_q;
    assign bus._ccb_l1accept = l1a_q;
    assign bus.l1a_drop      = drop_q;

endmodule

// File: tb/tb_ccb_tx_driver.sv
// Bench for ccb_tx_driver: two instances (STB_WIDTH 1 and 2) against a timing model.
module tb_ccb_tx_driver;

    localparam int BXP = 3564;
    localparam int GAP = 4;

    logic clk40  = 1'b0;
    logic _reset = 1'b0;

    always #5 clk40 = ~clk40;

    logic       cmd_req   = 1'b0;
    logic [7:0] cmd_code  = 8'h00;
    logic       data_req  = 1'b0;
    logic [7:0] data_byte = 8'h00;
    logic       l1a_req   = 1'b0;
    logic       bx0_en    = 1'b1;

    ccb_tx_driver_if if_w1 ();
    ccb_tx_driver_if if_w2 ();

    assign if_w1.cmd_req   = cmd_req;
    assign if_w1.cmd_code  = cmd_code;
    assign if_w1.data_req  = data_req;
    assign if_w1.data_byte = data_byte;
    assign if_w1.l1a_req   = l1a_req;
    assign if_w1.bx0_en    = bx0_en;
    assign if_w2.cmd_req   = cmd_req;
    assign if_w2.cmd_code  = cmd_code;
    assign if_w2.data_req  = data_req;
    assign if_w2.data_byte = data_byte;
    assign if_w2.l1a_req   = l1a_req;
    assign if_w2.bx0_en    = bx0_en;

    ccb_tx_driver #(.BX_PERIOD(BXP), .STB_WIDTH(1), .L1A_MIN_GAP(GAP)) u_dut_w1 (
        .clk40  (clk40),
        ._reset (_reset),
        .bus    (if_w1.slave)
    );

    ccb_tx_driver #(.BX_PERIOD(BXP), .STB_WIDTH(2), .L1A_MIN_GAP(GAP)) u_dut_w2 (
        .clk40  (clk40),
        ._reset (_reset),
        .bus    (if_w2.slave)
    );

    // Observed outputs as arrays: [instance][0=cmd,1=data]
    logic [7:0]  o_bus [2][2];
    logic        o_stb [2][2];
    logic        o_ack [2][2];
    logic        o_l1n [2];
    logic        o_drop[2];
    logic        o_bx0n[2];
    logic [11:0] o_bxn [2];

    assign o_bus[0][0] = if_w1._ccb_cmd;
    assign o_bus[0][1] = if_w1._ccb_data;
    assign o_stb[0][0] = if_w1._ccb_cmd_strobe;
    assign o_stb[0][1] = if_w1._ccb_data_strobe;
    assign o_ack[0][0] = if_w1.cmd_ack;
    assign o_ack[0][1] = if_w1.data_ack;
    assign o_l1n[0]    = if_w1._ccb_l1accept;
    assign o_drop[0]   = if_w1.l1a_drop;
    assign o_bx0n[0]   = if_w1._ccb_bx0;
    assign o_bxn[0]    = if_w1.bxn;
    assign o_bus[1][0] = if_w2._ccb_cmd;
    assign o_bus[1][1] = if_w2._ccb_data;
    assign o_stb[1][0] = if_w2._ccb_cmd_strobe;
    assign o_stb[1][1] = if_w2._ccb_data_strobe;
    assign o_ack[1][0] = if_w2.cmd_ack;
    assign o_ack[1][1] = if_w2.data_ack;
    assign o_l1n[1]    = if_w2._ccb_l1accept;
    assign o_drop[1]   = if_w2.l1a_drop;
    assign o_bx0n[1]   = if_w2._ccb_bx0;
    assign o_bxn[1]    = if_w2.bxn;

    int checks   = 0;
    int failures = 0;

    // Reference model: last acceptance edge and byte per channel, last L1A decision.
    int         edge_n   = 0;
    int         rst_edge = 0;
    bit         in_rst   = 1'b1;
    bit         bx0_last = 1'b1;
    int         acc_e [2][2];
    logic [7:0] acc_b [2][2];
    bit         acc_v [2][2];
    bit         l1_v;
    int         l1_last;
    int         l1_acc_e;
    int         l1_drop_e;

    function automatic int wid(input int i);
        return i + 1;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp_v, edge_n);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                acc_v[i][c] = 1'b0;
                acc_e[i][c] = -100;
                acc_b[i][c] = 8'h00;
            end
        end
        l1_v      = 1'b0;
        l1_last   = -100;
        l1_acc_e  = -100;
        l1_drop_e = -100;
    endtask

    // Apply the spec rules to the inputs present at the coming edge.
    task automatic model_edge();
        bit         rq [2];
        logic [7:0] bv [2];
        edge_n++;
        if (in_rst) return;
        rq[0] = cmd_req;  bv[0] = cmd_code;
        rq[1] = data_req; bv[1] = data_byte;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (rq[c] && (!acc_v[i][c] || (edge_n - acc_e[i][c] >= wid(i) + 3))) begin
                    acc_v[i][c] = 1'b1;
                    acc_e[i][c] = edge_n;
                    acc_b[i][c] = bv[c];
                end
            end
        end
        if (l1a_req) begin
            if (!l1_v || (edge_n - l1_last >= GAP)) begin
                l1_v     = 1'b1;
                l1_last  = edge_n;
                l1_acc_e = edge_n;
            end else begin
                l1_drop_e = edge_n;
            end
        end
        bx0_last = bx0_en;
    endtask

    task automatic check_all();
        int          o;
        logic [7:0]  e_bus;
        logic        e_stb;
        logic        e_ack;
        logic [11:0] e_bxn;
        logic        e_bx0n;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                o     = edge_n - acc_e[i][c];
                e_ack = acc_v[i][c] && (o == 0);
                e_bus = (acc_v[i][c] && o >= 0 && o <= wid(i) + 1) ? ~acc_b[i][c] : 8'hFF;
                e_stb = !(acc_v[i][c] && o >= 1 && o <= wid(i));
                chk($sformatf("w%0d_%s_ack", i + 1, (c == 0) ? "cmd" : "data"),
                    12'(o_ack[i][c]), 12'(e_ack));
                chk($sformatf("w%0d_%s_bus", i + 1, (c == 0) ? "cmd" : "data"),
                    12'(o_bus[i][c]), 12'(e_bus));
                chk($sformatf("w%0d_%s_strobe", i + 1, (c == 0) ? "cmd" : "data"),
                    12'(o_stb[i][c]), 12'(e_stb));
            end
            chk($sformatf("w%0d_l1accept", i + 1), 12'(o_l1n[i]),
                12'(!(l1_acc_e == edge_n && !in_rst)));
            chk($sformatf("w%0d_l1a_drop", i + 1), 12'(o_drop[i]),
                12'(l1_drop_e == edge_n && !in_rst));
            e_bxn  = in_rst ? 12'd0 : 12'((edge_n - rst_edge) % BXP);
            e_bx0n = !(!in_rst && edge_n > rst_edge && e_bxn == 12'd0 && bx0_last);
            chk($sformatf("w%0d_bxn", i + 1), o_bxn[i], e_bxn);
            chk($sformatf("w%0d_bx0", i + 1), 12'(o_bx0n[i]), 12'(e_bx0n));
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk40);
        @(negedge clk40);
        check_all();
    endtask

    initial begin
        int bx0_pulses;
        int orbit;

        // Reset state
        reset_model();
        repeat (3) cycle();
        _reset   = 1'b1;
        in_rst   = 1'b0;
        rst_edge = edge_n;

        // Single command pulse, 0x0C
        cmd_code = 8'h0C;
        cmd_req  = 1'b1;
        cycle();
        cmd_req  = 1'b0;
        chk("cmd_pulse_ack", 12'(o_ack[0][0]), 12'd1);
        chk("cmd_pulse_bus_k1", 12'(o_bus[0][0]), 12'h0F3);
        chk("cmd_pulse_stb_k1", 12'(o_stb[0][0]), 12'd1);
        cycle();
        chk("cmd_pulse_stb_k2", 12'(o_stb[0][0]), 12'd0);
        chk("cmd_pulse_ack_k2", 12'(o_ack[0][0]), 12'd0);
        cycle();
        chk("cmd_pulse_bus_k3", 12'(o_bus[0][0]), 12'h0F3);
        chk("cmd_pulse_stb_k3", 12'(o_stb[0][0]), 12'd1);
        cycle();
        chk("cmd_pulse_bus_k4", 12'(o_bus[0][0]), 12'h0FF);
        repeat (4) cycle();

        // Request held for 12 cycles with a new code every cycle
        cmd_req = 1'b1;
        for (int n = 0; n < 12; n++) begin
            cmd_code = 8'($urandom);
            cycle();
        end
        cmd_req = 1'b0;
        repeat (6) cycle();

        // Simultaneous command and data requests
        cmd_code  = 8'hA5;
        data_byte = 8'h3C;
        cmd_req   = 1'b1;
        data_req  = 1'b1;
        cycle();
        cmd_req   = 1'b0;
        data_req  = 1'b0;
        chk("both_cmd_bus", 12'(o_bus[1][0]), 12'h05A);
        chk("both_data_bus", 12'(o_bus[1][1]), 12'h0C3);
        repeat (6) cycle();

        // L1A at k, k+2, k+4 with gap 4
        repeat (GAP + 1) cycle();
        l1a_req = 1'b1; cycle(); l1a_req = 1'b0;
        chk("l1a_k_accept", 12'(o_l1n[0]), 12'd0);
        cycle();
        l1a_req = 1'b1; cycle(); l1a_req = 1'b0;
        chk("l1a_k2_drop", 12'(o_drop[1]), 12'd1);
        chk("l1a_k2_nopulse", 12'(o_l1n[1]), 12'd1);
        cycle();
        l1a_req = 1'b1; cycle(); l1a_req = 1'b0;
        chk("l1a_k4_accept", 12'(o_l1n[0]), 12'd0);
        cycle();

        // Random traffic across three orbit starts, BX0 disabled for the second
        bx0_pulses = 0;
        while ((edge_n - rst_edge) < 3 * BXP + 10) begin
            orbit     = (edge_n + 1 - rst_edge) / BXP;
            bx0_en    = (orbit != 2);
            cmd_req   = ($urandom_range(0, 3) == 0);
            cmd_code  = 8'($urandom);
            data_req  = ($urandom_range(0, 2) == 0);
            data_byte = 8'($urandom);
            l1a_req   = ($urandom_range(0, 2) == 0);
            cycle();
            if (o_bx0n[0] == 1'b0) bx0_pulses++;
        end
        chk("bx0_pulse_count", 12'(bx0_pulses), 12'd2);
        cmd_req  = 1'b0;
        data_req = 1'b0;
        l1a_req  = 1'b0;
        bx0_en   = 1'b1;
        repeat (8) cycle();

        // Reset asserted while both channels are strobing
        cmd_code  = 8'($urandom);
        data_byte = 8'($urandom);
        cmd_req   = 1'b1;
        data_req  = 1'b1;
        cycle();
        cmd_req   = 1'b0;
        data_req  = 1'b0;
        cycle();
        chk("pre_rst_strobe_low", 12'(o_stb[1][0]), 12'd0);
        #2;
        _reset = 1'b0;
        in_rst = 1'b1;
        reset_model();
        #1;
        chk("rst_cmd_strobe", 12'(o_stb[1][0]), 12'd1);
        chk("rst_cmd_bus", 12'(o_bus[1][0]), 12'h0FF);
        chk("rst_bxn", o_bxn[0], 12'd0);
        check_all();
        repeat (2) cycle();
        _reset   = 1'b1;
        in_rst   = 1'b0;
        rst_edge = edge_n;
        l1a_req  = 1'b1;
        cycle();
        l1a_req  = 1'b0;
        chk("post_rst_l1a_w1", 12'(o_l1n[0]), 12'd0);
        chk("post_rst_l1a_w2", 12'(o_l1n[1]), 12'd0);
        repeat (6) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
